// File: rtl/adc_capture_ctrl.sv
// ADC sample capture sequencer: frames the free-running ADC stream into AXI4-Stream beats via a FWFT FIFO.
// Optional SOF flag on m_axis_tuser when ADC_CAPTURE_SOF_EN is defined.
module adc_capture_ctrl #(
  parameter int unsigned ADC_W      = 14,
  parameter int unsigned TDATA_W    = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               adc_clk,
  input  logic               adc_rst,
  input  logic [ADC_W-1:0]   adc_data,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [LEN_W-1:0]   frame_len,
  output logic [TDATA_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               busy,
  output logic               overflow,
  output logic [CNT_W-1:0]   drop_count,
  output logic [CNT_W-1:0]   frames_done
`ifdef ADC_CAPTURE_SOF_EN
  ,
  output logic               m_axis_tuser
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
`ifdef ADC_CAPTURE_SOF_EN
  localparam int unsigned ENT_W = ADC_W + 2;
`else
  localparam int unsigned ENT_W = ADC_W + 1;
`endif
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [ADC_W-1:0]   sample_q;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic               cont_q, cont_d;
  logic               stop_pend_q, stop_pend_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [CNT_W-1:0]   frames_q, frames_d;
  logic [AW:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]   mem_d [FIFO_DEPTH];

  logic [AW:0]        count;
  logic               full, empty, wr_en, rd_en, wr_last;
  logic [ENT_W-1:0]   wr_entry, rd_entry;

  assign count    = wptr_q - rptr_q;
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign rd_entry = mem_q[rptr_q[AW-1:0]];
  assign rd_en    = !empty && m_axis_tready;
  assign wr_last  = (idx_q == len_q - LEN_W'(1));
`ifdef ADC_CAPTURE_SOF_EN
  assign wr_entry = {(idx_q == '0), wr_last, sample_q};
`else
  assign wr_entry = {wr_last, sample_q};
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    overflow_d  = overflow_q;
    drop_d      = drop_q;
    frames_d    = frames_q;
    wr_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && frame_len != '0) begin
          state_d     = ST_CAPTURE;
          len_d       = frame_len;
          cont_d      = continuous;
          idx_d       = '0;
          stop_pend_d = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (stop) stop_pend_d = 1'b1;
        // Full is judged on pre-edge occupancy; a same-edge read never rescues the write.
        if (!full) begin
          wr_en = 1'b1;
          if (wr_last) begin
            if (cont_q && !stop_pend_q && !stop) idx_d = '0;
            else state_d = ST_DRAIN;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end else begin
          overflow_d = 1'b1;
          if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rd_en && rd_entry[ADC_W] && frames_q != '1) frames_d = frames_q + CNT_W'(1);
  end

  always_comb begin
    wptr_d = wr_en ? wptr_q + (AW + 1)'(1) : wptr_q;
    rptr_d = rd_en ? rptr_q + (AW + 1)'(1) : rptr_q;
    mem_d  = mem_q;
    if (wr_en) mem_d[wptr_q[AW-1:0]] = wr_entry;
  end

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      state_q     <= ST_IDLE;
      sample_q    <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
      frames_q    <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      sample_q    <= adc_data;
      len_q       <= len_d;
      idx_q       <= idx_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
      frames_q    <= frames_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  // Storage needs no reset: pointers alone define validity.
  always_ff @(posedge adc_clk) begin
    mem_q <= mem_d;
  end

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0 : TDATA_W'(rd_entry[ADC_W-1:0]);
  assign m_axis_tlast  = !empty && rd_entry[ADC_W];
`ifdef ADC_CAPTURE_SOF_EN
  assign m_axis_tuser  = !empty && rd_entry[ADC_W+1];
`endif
  assign busy          = (state_q != ST_IDLE);
  assign overflow      = overflow_q;
  assign drop_count    = drop_q;
  assign frames_done   = frames_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed self-checking bench for adc_capture_ctrl; SOF scenario runs only with ADC_CAPTURE_SOF_EN.
module tb_adc_capture_ctrl;

  logic        adc_clk = 1'b0;
  logic        adc_rst;
  logic [13:0] adc_data;
  logic        start, stop, continuous;
  logic [15:0] frame_len;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic        busy, overflow;
  logic [15:0] drop_count, frames_done;
  logic        tuser_w;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] d;
    logic        l;
    logic        u;
  } beat_t;
  beat_t beats[$];

  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_d;
  logic        prev_l;

  adc_capture_ctrl #(
    .ADC_W(14), .TDATA_W(16), .FIFO_DEPTH(8), .LEN_W(16), .CNT_W(16)
  ) dut (
    .adc_clk       (adc_clk),
    .adc_rst       (adc_rst),
    .adc_data      (adc_data),
    .start         (start),
    .stop          (stop),
    .continuous    (continuous),
    .frame_len     (frame_len),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .frames_done   (frames_done)
`ifdef ADC_CAPTURE_SOF_EN
    ,
    .m_axis_tuser  (tuser_w)
`endif
  );
`ifndef ADC_CAPTURE_SOF_EN
  assign tuser_w = 1'b0;
`endif

  always #5 adc_clk = ~adc_clk;

  // Free-running ADC counter, stepped 1 time unit after each rising edge.
  initial begin
    adc_data = 14'd0;
    forever begin
      @(posedge adc_clk);
      #1 adc_data = adc_data + 14'd1;
    end
  end

  always @(negedge adc_clk) begin
    if (adc_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l))
        stall_viol++;
      if (m_axis_tvalid && m_axis_tready)
        beats.push_back('{d: m_axis_tdata, l: m_axis_tlast, u: tuser_w});
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d     = m_axis_tdata;
      prev_l     = m_axis_tlast;
    end
  end

  task automatic tick();
    @(posedge adc_clk);
    #2;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      $display("FAIL %s_idle_timeout busy=%0b after %0d cycles, required 0", name, busy, n);
      failures++;
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    adc_rst = 1'b1; start = 0; stop = 0; continuous = 0; frame_len = 0; m_axis_tready = 1;
    repeat (3) tick();
    adc_rst = 1'b0;
    tick();
    checks++; if (m_axis_tvalid !== 1'b0) begin $display("FAIL reset_tvalid got %0b want 0", m_axis_tvalid); failures++; end
    checks++; if (m_axis_tdata !== 16'd0) begin $display("FAIL reset_tdata got %0d want 0", m_axis_tdata); failures++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %0b want 0", busy); failures++; end
    checks++; if (overflow !== 1'b0) begin $display("FAIL reset_overflow got %0b want 0", overflow); failures++; end
    checks++; if (drop_count !== 16'd0) begin $display("FAIL reset_drop got %0d want 0", drop_count); failures++; end
    checks++; if (frames_done !== 16'd0) begin $display("FAIL reset_frames got %0d want 0", frames_done); failures++; end
  endtask

  task automatic test_single();
    logic [13:0] base, e;
    beats.delete();
    frame_len = 16'd4; continuous = 0; m_axis_tready = 1; start = 1;
    base = adc_data;
    tick();
    start = 0;
    checks++; if (m_axis_tvalid !== 1'b0) begin $display("FAIL single_tvalid_early got %0b want 0", m_axis_tvalid); failures++; end
    tick();
    checks++; if (m_axis_tvalid !== 1'b1) begin $display("FAIL single_tvalid_latency got %0b want 1", m_axis_tvalid); failures++; end
    wait_idle(40, "single");
    checks++; if (beats.size() !== 4) begin $display("FAIL single_count got %0d want 4", beats.size()); failures++; end
    for (int i = 0; i < beats.size() && i < 4; i++) begin
      e = base + 14'(i);
      checks++; if (beats[i].d !== {2'b00, e}) begin $display("FAIL single_data[%0d] got %0d want %0d", i, beats[i].d, e); failures++; end
      checks++; if (beats[i].l !== (i == 3)) begin $display("FAIL single_tlast[%0d] got %0b want %0b", i, beats[i].l, i == 3); failures++; end
    end
    checks++; if (frames_done !== 16'd1) begin $display("FAIL single_frames got %0d want 1", frames_done); failures++; end
    checks++; if (drop_count !== 16'd0) begin $display("FAIL single_drop got %0d want 0", drop_count); failures++; end
  endtask

  task automatic test_backpressure();
    logic [13:0] base, e;
    beats.delete();
    stall_viol = 0;
    frame_len = 16'd16; continuous = 0; m_axis_tready = 0; start = 1;
    base = adc_data;
    tick();
    start = 0;
    repeat (19) tick();
    m_axis_tready = 1;
    wait_idle(60, "bp");
    checks++; if (beats.size() !== 16) begin $display("FAIL bp_count got %0d want 16", beats.size()); failures++; end
    for (int i = 0; i < beats.size() && i < 16; i++) begin
      e = base + 14'((i < 8) ? i : i + 12);
      checks++; if (beats[i].d !== {2'b00, e}) begin $display("FAIL bp_data[%0d] got %0d want %0d", i, beats[i].d, e); failures++; end
      checks++; if (beats[i].l !== (i == 15)) begin $display("FAIL bp_tlast[%0d] got %0b want %0b", i, beats[i].l, i == 15); failures++; end
    end
    checks++; if (drop_count !== 16'd12) begin $display("FAIL bp_drop got %0d want 12", drop_count); failures++; end
    checks++; if (overflow !== 1'b1) begin $display("FAIL bp_overflow got %0b want 1", overflow); failures++; end
    checks++; if (frames_done !== 16'd2) begin $display("FAIL bp_frames got %0d want 2", frames_done); failures++; end
    checks++; if (stall_viol !== 0) begin $display("FAIL bp_stall_stable got %0d violations want 0", stall_viol); failures++; end
  endtask

  task automatic test_continuous();
    logic [13:0] base, e;
    beats.delete();
    frame_len = 16'd4; continuous = 1; m_axis_tready = 1; start = 1;
    base = adc_data;
    tick();
    start = 0; continuous = 0;
    repeat (5) tick();
    stop = 1;
    tick();
    stop = 0;
    wait_idle(40, "cont");
    repeat (5) tick();
    checks++; if (beats.size() !== 8) begin $display("FAIL cont_count got %0d want 8", beats.size()); failures++; end
    for (int i = 0; i < beats.size() && i < 8; i++) begin
      e = base + 14'(i);
      checks++; if (beats[i].d !== {2'b00, e}) begin $display("FAIL cont_data[%0d] got %0d want %0d", i, beats[i].d, e); failures++; end
      checks++; if (beats[i].l !== (i == 3 || i == 7)) begin $display("FAIL cont_tlast[%0d] got %0b want %0b", i, beats[i].l, i == 3 || i == 7); failures++; end
    end
    checks++; if (frames_done !== 16'd4) begin $display("FAIL cont_frames got %0d want 4", frames_done); failures++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL cont_busy got %0b want 0", busy); failures++; end
  endtask

  task automatic test_ignored();
    logic [13:0] base, e;
    beats.delete();
    frame_len = 16'd0; continuous = 0; m_axis_tready = 1; start = 1;
    repeat (3) tick();
    start = 0;
    checks++; if (busy !== 1'b0) begin $display("FAIL ign_len0_busy got %0b want 0", busy); failures++; end
    stop = 1; tick(); stop = 0;
    checks++; if (beats.size() !== 0) begin $display("FAIL ign_len0_beats got %0d want 0", beats.size()); failures++; end
    frame_len = 16'd4; m_axis_tready = 0; start = 1;
    base = adc_data;
    tick();
    start = 0;
    repeat (2) tick();
    frame_len = 16'd8; continuous = 1; start = 1;
    tick();
    start = 0; continuous = 0;
    repeat (4) tick();
    m_axis_tready = 1;
    wait_idle(40, "ign");
    repeat (5) tick();
    checks++; if (beats.size() !== 4) begin $display("FAIL ign_busy_count got %0d want 4", beats.size()); failures++; end
    for (int i = 0; i < beats.size() && i < 4; i++) begin
      e = base + 14'(i);
      checks++; if (beats[i].d !== {2'b00, e}) begin $display("FAIL ign_data[%0d] got %0d want %0d", i, beats[i].d, e); failures++; end
    end
    checks++; if (frames_done !== 16'd5) begin $display("FAIL ign_frames got %0d want 5", frames_done); failures++; end
    checks++; if (drop_count !== 16'd12) begin $display("FAIL ign_drop got %0d want 12", drop_count); failures++; end
  endtask

  task automatic test_reset_mid();
    logic [13:0] base, e;
    beats.delete();
    frame_len = 16'd8; continuous = 0; m_axis_tready = 0; start = 1;
    tick();
    start = 0;
    repeat (3) tick();
    checks++; if (m_axis_tvalid !== 1'b1) begin $display("FAIL rmid_pre_tvalid got %0b want 1", m_axis_tvalid); failures++; end
    adc_rst = 1'b1;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin $display("FAIL rmid_tvalid got %0b want 0", m_axis_tvalid); failures++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL rmid_busy got %0b want 0", busy); failures++; end
    checks++; if (drop_count !== 16'd0 || frames_done !== 16'd0 || overflow !== 1'b0) begin
      $display("FAIL rmid_counters got drop=%0d frames=%0d ovf=%0b want 0/0/0", drop_count, frames_done, overflow); failures++; end
    tick();
    adc_rst = 1'b0;
    m_axis_tready = 1;
    tick();
    beats.delete();
    frame_len = 16'd3; start = 1;
    base = adc_data;
    tick();
    start = 0;
    wait_idle(40, "rmid");
    checks++; if (beats.size() !== 3) begin $display("FAIL rmid_count got %0d want 3", beats.size()); failures++; end
    for (int i = 0; i < beats.size() && i < 3; i++) begin
      e = base + 14'(i);
      checks++; if (beats[i].d !== {2'b00, e}) begin $display("FAIL rmid_data[%0d] got %0d want %0d", i, beats[i].d, e); failures++; end
      checks++; if (beats[i].l !== (i == 2)) begin $display("FAIL rmid_tlast[%0d] got %0b want %0b", i, beats[i].l, i == 2); failures++; end
    end
    checks++; if (frames_done !== 16'd1) begin $display("FAIL rmid_frames got %0d want 1", frames_done); failures++; end
  endtask

`ifdef ADC_CAPTURE_SOF_EN
  task automatic test_sof();
    beats.delete();
    frame_len = 16'd3; continuous = 1; m_axis_tready = 1; start = 1;
    tick();
    start = 0; continuous = 0;
    for (int c = 0; c < 30; c++) begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
      stop = (c == 12);
      tick();
    end
    stop = 0;
    m_axis_tready = 1;
    wait_idle(60, "sof");
    checks++; if (beats.size() < 9 || (beats.size() % 3) != 0) begin $display("FAIL sof_count got %0d want multiple of 3 >= 9", beats.size()); failures++; end
    for (int i = 0; i < beats.size(); i++) begin
      checks++; if (beats[i].u !== ((i % 3) == 0)) begin $display("FAIL sof_tuser[%0d] got %0b want %0b", i, beats[i].u, (i % 3) == 0); failures++; end
      checks++; if (beats[i].l !== ((i % 3) == 2)) begin $display("FAIL sof_tlast[%0d] got %0b want %0b", i, beats[i].l, (i % 3) == 2); failures++; end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_continuous();
    test_ignored();
    test_reset_mid();
`ifdef ADC_CAPTURE_SOF_EN
    test_sof();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
